// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, funct and ALU control-word definitions
//
// Purpose: constants shared by the decode stage and the execute-stage ALU.
// The ALU control word is one-hot, ALU_OP_W bits wide, with the bit order
// given by the ALU_* indices below.
package cpu_pkg;

    localparam int ALU_OP_W = 12;

    // One-hot ALU control word bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // Build a one-hot control word with only bit idx set
    function automatic logic [ALU_OP_W-1:0] alu_bit(input int idx);
        return {{(ALU_OP_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - combinational instruction decoder for the ID stage
//
// Purpose: turn one 32-bit instruction word into ALU control, operand
// selects, extended immediate, destination and enables.
// Ports:
//   inst      in  32  instruction word
//   alu_op    out 12  one-hot ALU control word (zero when illegal)
//   src1_sa   out 1   operand 1 is the shift amount instead of rs data
//   src2_imm  out 1   operand 2 is the extended immediate instead of rt data
//   imm       out 32  imm16, zero- or sign-extended as the opcode requires
//   sa        out 5   shift amount field
//   rs, rt    out 5   source register indices
//   dest      out 5   rd for R-type, rt for I-type
//   rf_we     out 1   register write enable
//   mem_re    out 1   load
//   mem_we    out 1   store
//   illegal   out 1   undecoded opcode (only when ILLEGAL_TRAP=1)
module inst_decoder
    import cpu_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic [31:0]         inst,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                src1_sa,
    output logic                src2_imm,
    output logic [31:0]         imm,
    output logic [4:0]          sa,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          dest,
    output logic                rf_we,
    output logic                mem_re,
    output logic                mem_we,
    output logic                illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        is_rtype;
    logic        ext_zero;
    logic        legal;

    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign sa       = inst[10:6];
    assign funct    = inst[5:0];
    assign imm16    = inst[15:0];
    assign is_rtype = (opcode == OP_SPECIAL);

    always_comb begin
        alu_op   = '0;
        src1_sa  = 1'b0;
        ext_zero = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL:  begin alu_op = alu_bit(ALU_SLL); src1_sa = 1'b1; end
                    FN_SRL:  begin alu_op = alu_bit(ALU_SRL); src1_sa = 1'b1; end
                    FN_SRA:  begin alu_op = alu_bit(ALU_SRA); src1_sa = 1'b1; end
                    FN_SLLV: alu_op = alu_bit(ALU_SLL);
                    FN_SRLV: alu_op = alu_bit(ALU_SRL);
                    FN_SRAV: alu_op = alu_bit(ALU_SRA);
                    FN_ADDU: alu_op = alu_bit(ALU_ADD);
                    FN_SUBU: alu_op = alu_bit(ALU_SUB);
                    FN_AND:  alu_op = alu_bit(ALU_AND);
                    FN_OR:   alu_op = alu_bit(ALU_OR);
                    FN_XOR:  alu_op = alu_bit(ALU_XOR);
                    FN_NOR:  alu_op = alu_bit(ALU_NOR);
                    FN_SLT:  alu_op = alu_bit(ALU_SLT);
                    FN_SLTU: alu_op = alu_bit(ALU_SLTU);
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU: alu_op = alu_bit(ALU_ADD);
            OP_SLTI:  alu_op = alu_bit(ALU_SLT);
            OP_SLTIU: alu_op = alu_bit(ALU_SLTU);
            OP_ANDI:  begin alu_op = alu_bit(ALU_AND); ext_zero = 1'b1; end
            OP_ORI:   begin alu_op = alu_bit(ALU_OR);  ext_zero = 1'b1; end
            OP_XORI:  begin alu_op = alu_bit(ALU_XOR); ext_zero = 1'b1; end
            OP_LUI:   alu_op = alu_bit(ALU_LUI);
            OP_LW:    begin alu_op = alu_bit(ALU_ADD); mem_re = 1'b1; end
            OP_SW:    begin alu_op = alu_bit(ALU_ADD); mem_we = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Every I-type (including LUI and illegal opcodes) takes the immediate
    assign src2_imm = ~is_rtype;
    assign imm      = ext_zero ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    assign dest     = is_rtype ? rd : rt;

    // Writes to $0 are suppressed here so later stages never see them
    assign rf_we    = legal & ~mem_we & (dest != 5'd0);
    assign illegal  = ~legal & ILLEGAL_TRAP;

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - decode stage shell: DS slot, ID/EX slot, flow control
//
// Purpose: holds the fetched instruction in the DS slot, decodes it, builds
// the ALU operands from register-file data and hands the result to the
// registered ID/EX slot with valid/allowin handshaking.
// Ports:
//   clk, reset                      clock, async active-high reset
//   fs_valid, fs_inst, fs_pc        instruction offered by IF
//   ds_allowin                      DS slot can accept this cycle
//   rf_raddr1/2, rf_rdata1/2        register-file read port (combinational)
//   hazard_stall                    RAW interlock, holds the DS slot
//   flush                           discard both slots
//   ex_allowin                      execute stage accepts
//   ex_valid .. ex_illegal          registered ID/EX slot contents
module id_decode_stage
    import cpu_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fs_valid,
    input  logic [31:0]         fs_inst,
    input  logic [31:0]         fs_pc,
    output logic                ds_allowin,
    output logic [4:0]          rf_raddr1,
    output logic [4:0]          rf_raddr2,
    input  logic [31:0]         rf_rdata1,
    input  logic [31:0]         rf_rdata2,
    input  logic                hazard_stall,
    input  logic                flush,
    input  logic                ex_allowin,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [31:0]         ex_alu_src1,
    output logic [31:0]         ex_alu_src2,
    output logic [4:0]          ex_dest,
    output logic                ex_rf_we,
    output logic                ex_mem_re,
    output logic                ex_mem_we,
    output logic [31:0]         ex_store_data,
    output logic [31:0]         ex_pc,
    output logic                ex_illegal
);

    logic        ds_valid;
    logic [31:0] ds_inst;
    logic [31:0] ds_pc;

    logic        ds_ready_go;
    logic        ex_cango;
    logic        ds_to_ex;

    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_src1_sa;
    logic                dec_src2_imm;
    logic [31:0]         dec_imm;
    logic [4:0]          dec_sa;
    logic [4:0]          dec_dest;
    logic                dec_rf_we;
    logic                dec_mem_re;
    logic                dec_mem_we;
    logic                dec_illegal;
    logic [31:0]         src1;
    logic [31:0]         src2;

    inst_decoder #(
        .ILLEGAL_TRAP (ILLEGAL_TRAP)
    ) u_dec (
        .inst     (ds_inst),
        .alu_op   (dec_alu_op),
        .src1_sa  (dec_src1_sa),
        .src2_imm (dec_src2_imm),
        .imm      (dec_imm),
        .sa       (dec_sa),
        .rs       (rf_raddr1),
        .rt       (rf_raddr2),
        .dest     (dec_dest),
        .rf_we    (dec_rf_we),
        .mem_re   (dec_mem_re),
        .mem_we   (dec_mem_we),
        .illegal  (dec_illegal)
    );

    assign src1 = dec_src1_sa  ? {27'd0, dec_sa} : rf_rdata1;
    assign src2 = dec_src2_imm ? dec_imm         : rf_rdata2;

    assign ds_ready_go = ~hazard_stall;
    assign ex_cango    = ~ex_valid | ex_allowin;
    assign ds_allowin  = ~ds_valid | (ds_ready_go & ex_cango);
    assign ds_to_ex    = ds_valid & ds_ready_go & ex_cango;

    // DS slot; data only moves when a new instruction actually enters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_inst  <= '0;
            ds_pc    <= '0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_valid;
            if (fs_valid) begin
                ds_inst <= fs_inst;
                ds_pc   <= fs_pc;
            end
        end
    end

    // ID/EX slot; when EX drains with nothing behind it, valid falls (bubble)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= '0;
            ex_alu_src1   <= '0;
            ex_alu_src2   <= '0;
            ex_dest       <= '0;
            ex_rf_we      <= 1'b0;
            ex_mem_re     <= 1'b0;
            ex_mem_we     <= 1'b0;
            ex_store_data <= '0;
            ex_pc         <= '0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_cango) begin
            ex_valid <= ds_to_ex;
            if (ds_to_ex) begin
                ex_alu_op     <= dec_alu_op;
                ex_alu_src1   <= src1;
                ex_alu_src2   <= src2;
                ex_dest       <= dec_dest;
                ex_rf_we      <= dec_rf_we;
                ex_mem_re     <= dec_mem_re;
                ex_mem_we     <= dec_mem_we;
                ex_store_data <= rf_rdata2;
                ex_pc         <= ds_pc;
                ex_illegal    <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - self-checking bench for id_decode_stage
module tb_id_decode_stage;

    typedef struct packed {
        logic [11:0] op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        we;
        logic        re;
        logic        mwe;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        exp_t        exp;
        bit          chk_ops;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        ds_allowin;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        hazard_stall;
    logic        flush;
    logic        ex_allowin;
    logic        ex_valid;
    logic [11:0] ex_alu_op;
    logic [31:0] ex_alu_src1;
    logic [31:0] ex_alu_src2;
    logic [4:0]  ex_dest;
    logic        ex_rf_we;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    logic [31:0] regs [32];
    int applied = 0;
    int miscompares = 0;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .fs_valid      (fs_valid),
        .fs_inst       (fs_inst),
        .fs_pc         (fs_pc),
        .ds_allowin    (ds_allowin),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .hazard_stall  (hazard_stall),
        .flush         (flush),
        .ex_allowin    (ex_allowin),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src1   (ex_alu_src1),
        .ex_alu_src2   (ex_alu_src2),
        .ex_dest       (ex_dest),
        .ex_rf_we      (ex_rf_we),
        .ex_mem_re     (ex_mem_re),
        .ex_mem_we     (ex_mem_we),
        .ex_store_data (ex_store_data),
        .ex_pc         (ex_pc),
        .ex_illegal    (ex_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] sd, input logic [4:0] dest, input logic we,
                                input logic re, input logic mwe, input logic ill);
        exp_t e;
        e.op = op; e.src1 = s1; e.src2 = s2; e.sd = sd; e.dest = dest;
        e.we = we; e.re = re; e.mwe = mwe; e.ill = ill;
        return e;
    endfunction

    // Reference decode: mnemonic -> ALU bit number, then operands from the ISA rules
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   k = -1;
        bit   r = (w[31:26] == 6'h00);
        bit   shamt = 0;
        bit   zx = 0;
        int   s;
        if (r) begin
            case (w[5:0])
                6'h21: k = 0;  6'h23: k = 1;  6'h2a: k = 2;  6'h2b: k = 3;
                6'h24: k = 4;  6'h27: k = 5;  6'h25: k = 6;  6'h26: k = 7;
                6'h00: begin k = 8;  shamt = 1; end
                6'h02: begin k = 9;  shamt = 1; end
                6'h03: begin k = 10; shamt = 1; end
                6'h04: k = 8;  6'h06: k = 9;  6'h07: k = 10;
                default: k = -1;
            endcase
        end else begin
            case (w[31:26])
                6'h09, 6'h23, 6'h2b: k = 0;
                6'h0a: k = 2;
                6'h0b: k = 3;
                6'h0c: begin k = 4; zx = 1; end
                6'h0d: begin k = 6; zx = 1; end
                6'h0e: begin k = 7; zx = 1; end
                6'h0f: k = 11;
                default: k = -1;
            endcase
        end
        s = int'(w[15:0]);
        if (!zx && s >= 32768) s -= 65536;
        e.op   = (k < 0) ? 12'h000 : 12'(1 << k);
        e.src1 = shamt ? 32'(w[10:6]) : regs[w[25:21]];
        e.src2 = r ? regs[w[20:16]] : 32'(s);
        e.sd   = regs[w[20:16]];
        e.dest = r ? w[15:11] : w[20:16];
        e.mwe  = (k >= 0) && (w[31:26] == 6'h2b);
        e.re   = (k >= 0) && (w[31:26] == 6'h23);
        e.we   = (k >= 0) && !e.mwe && (e.dest != 5'd0);
        e.ill  = (k < 0);
        return e;
    endfunction

    task automatic check_ex(input string tag, input exp_t e, input bit ops, input logic [31:0] pc);
        check({tag, ".alu_op"}, 32'(ex_alu_op), 32'(e.op));
        if (ops) begin
            check({tag, ".src1"}, ex_alu_src1, e.src1);
            check({tag, ".src2"}, ex_alu_src2, e.src2);
            check({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
        end
        check({tag, ".store_data"}, ex_store_data, e.sd);
        check({tag, ".rf_we"}, 32'(ex_rf_we), 32'(e.we));
        check({tag, ".mem_re"}, 32'(ex_mem_re), 32'(e.re));
        check({tag, ".mem_we"}, 32'(ex_mem_we), 32'(e.mwe));
        check({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
        check({tag, ".pc"}, ex_pc, pc);
    endtask

    task automatic idle(input int n);
        fs_valid = 1'b0; flush = 1'b0; hazard_stall = 1'b0; ex_allowin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single instruction through an empty pipe: accept at edge N, visible after N+1
    task automatic run_one(input string tag, input vec_t v, input logic [31:0] pc);
        fs_valid = 1'b1; fs_inst = v.inst; fs_pc = pc; ex_allowin = 1'b1;
        @(posedge clk); #1;
        fs_valid = 1'b0;
        check({tag, ".lat_n"}, 32'(ex_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'd1);
        check_ex(tag, v.exp, v.chk_ops, pc);
    endtask

    function automatic logic [31:0] rand_inst();
        int k = $urandom_range(0, 23);
        logic [31:0] w = $urandom;
        case (k)
            0:  w[5:0] = 6'h00;  1:  w[5:0] = 6'h02;  2:  w[5:0] = 6'h03;
            3:  w[5:0] = 6'h04;  4:  w[5:0] = 6'h06;  5:  w[5:0] = 6'h07;
            6:  w[5:0] = 6'h21;  7:  w[5:0] = 6'h23;  8:  w[5:0] = 6'h24;
            9:  w[5:0] = 6'h25;  10: w[5:0] = 6'h26;  11: w[5:0] = 6'h27;
            12: w[5:0] = 6'h2a;  13: w[5:0] = 6'h2b;
            14: w[31:26] = 6'h09; 15: w[31:26] = 6'h0a; 16: w[31:26] = 6'h0b;
            17: w[31:26] = 6'h0c; 18: w[31:26] = 6'h0d; 19: w[31:26] = 6'h0e;
            20: w[31:26] = 6'h0f; 21: w[31:26] = 6'h23; 22: w[31:26] = 6'h2b;
            default: ;
        endcase
        if (k <= 13) w[31:26] = 6'h00;
        return w;
    endfunction

    vec_t  tbl [11];
    vec_t  va, vb, vc;
    item_t q [$];
    int    seen [$];
    bit    ex_full;
    bit    ds_has;
    bit    exp_allowin;
    bit    consume;
    bit    move;
    bit    acc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'd0; regs[1] = 32'd5; regs[4] = 32'd1;

        tbl[0]  = '{32'h2422FFFF, mk(12'h001, 32'd5, 32'hFFFFFFFF, 32'h10000002, 5'd2, 1, 0, 0, 0), 1};
        tbl[1]  = '{32'h000419C0, mk(12'h100, 32'd7, 32'd1,        32'd1,        5'd3, 1, 0, 0, 0), 1};
        tbl[2]  = '{32'h34258000, mk(12'h040, 32'd5, 32'h00008000, 32'h10000005, 5'd5, 1, 0, 0, 0), 1};
        tbl[3]  = '{32'hAC250004, mk(12'h001, 32'd5, 32'd4,        32'h10000005, 5'd5, 0, 0, 1, 0), 1};
        tbl[4]  = '{32'h8C86FFF8, mk(12'h001, 32'd1, 32'hFFFFFFF8, 32'h10000006, 5'd6, 1, 1, 0, 0), 1};
        tbl[5]  = '{32'h00240021, mk(12'h001, 32'd5, 32'd1,        32'd1,        5'd0, 0, 0, 0, 0), 1};
        tbl[6]  = '{32'h00243807, mk(12'h400, 32'd5, 32'd1,        32'd1,        5'd7, 1, 0, 0, 0), 1};
        tbl[7]  = '{32'h3C088001, mk(12'h800, 32'd0, 32'hFFFF8001, 32'h10000008, 5'd8, 1, 0, 0, 0), 1};
        tbl[8]  = '{32'h2C29FFFF, mk(12'h008, 32'd5, 32'hFFFFFFFF, 32'h10000009, 5'd9, 1, 0, 0, 0), 1};
        tbl[9]  = '{32'hFC000000, mk(12'h000, 32'd0, 32'd0,        32'd0,        5'd0, 0, 0, 0, 1), 0};
        tbl[10] = '{32'h00000001, mk(12'h000, 32'd0, 32'd0,        32'd0,        5'd0, 0, 0, 0, 1), 0};

        reset = 1'b1; fs_valid = 1'b0; fs_inst = '0; fs_pc = '0;
        hazard_stall = 1'b0; flush = 1'b0; ex_allowin = 1'b1;
        #1;
        check("rst.ds_allowin", 32'(ds_allowin), 32'd1);
        check("rst.ex_valid", 32'(ex_valid), 32'd0);
        check("rst.alu_op", 32'(ex_alu_op), 32'd0);
        check("rst.src1", ex_alu_src1, 32'd0);
        check("rst.src2", ex_alu_src2, 32'd0);
        check("rst.dest", 32'(ex_dest), 32'd0);
        check("rst.rf_we", 32'(ex_rf_we), 32'd0);
        check("rst.mem", 32'({ex_mem_re, ex_mem_we}), 32'd0);
        check("rst.illegal", 32'(ex_illegal), 32'd0);
        check("rst.pc", ex_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) run_one($sformatf("vec%0d", i), tbl[i], 32'h1000 + 32'(i * 4));

        // Backpressure: A, B, C back to back with EX stalled for three cycles
        va = tbl[0]; vb = tbl[2]; vc = tbl[1];
        idle(2);
        ex_allowin = 1'b0; fs_valid = 1'b1; fs_inst = va.inst;
        @(posedge clk); #1 fs_inst = vb.inst;
        @(posedge clk); #1 fs_inst = vc.inst;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.ds_allowin", 32'(ds_allowin), 32'd0);
            check("bp.ex_valid", 32'(ex_valid), 32'd1);
            check("bp.ex_dest", 32'(ex_dest), 32'd2);
            if (c < 2) begin @(posedge clk); #1; end
        end
        ex_allowin = 1'b1;
        seen.delete();
        for (int c = 0; c < 10; c++) begin
            #1;
            acc = fs_valid && ds_allowin;
            if (ex_valid) seen.push_back(int'(ex_dest));
            @(posedge clk); #1;
            if (acc) fs_valid = 1'b0;
        end
        check("bp.count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("bp.order0", 32'(seen[0]), 32'd2);
            check("bp.order1", 32'(seen[1]), 32'd5);
            check("bp.order2", 32'(seen[2]), 32'd3);
        end

        // Flush with both slots full and IF offering a third instruction
        idle(1);
        ex_allowin = 1'b0; fs_valid = 1'b1; fs_inst = va.inst;
        @(posedge clk); #1 fs_inst = vb.inst;
        @(posedge clk); #1;
        check("fl.full", 32'(ds_allowin), 32'd0);
        fs_inst = vc.inst; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; fs_valid = 1'b0;
        check("fl.ex_valid", 32'(ex_valid), 32'd0);
        check("fl.ds_allowin", 32'(ds_allowin), 32'd1);
        ex_allowin = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("fl.no_issue", 32'(ex_valid), 32'd0);
        end

        // Asynchronous reset mid-stream
        ex_allowin = 1'b0; fs_valid = 1'b1; fs_inst = va.inst;
        @(posedge clk); #1 fs_inst = vb.inst;
        @(posedge clk); #1 fs_valid = 1'b0;
        check("ar.pre", 32'(ex_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar.ex_valid", 32'(ex_valid), 32'd0);
        check("ar.ds_allowin", 32'(ds_allowin), 32'd1);
        check("ar.alu_op", 32'(ex_alu_op), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        ex_allowin = 1'b1;
        run_one("ar.after", tbl[0], 32'h2000);

        // Randomized traffic against the queue model
        idle(2);
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        q.delete(); ex_full = 0;
        for (int c = 0; c < 600; c++) begin
            fs_valid = ($urandom_range(0, 3) != 0);
            fs_inst = rand_inst();
            fs_pc = $urandom;
            ex_allowin = ($urandom_range(0, 3) != 0);
            hazard_stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 31) == 0);
            #1;
            ds_has = q.size() > (ex_full ? 1 : 0);
            exp_allowin = !ds_has || (!hazard_stall && (!ex_full || ex_allowin));
            check("rnd.ds_allowin", 32'(ds_allowin), 32'(exp_allowin));
            check("rnd.ex_valid", 32'(ex_valid), 32'(ex_full));
            if (ex_full && ex_valid) check_ex("rnd", model(q[0].inst), !model(q[0].inst).ill, q[0].pc);
            if (flush) begin
                q.delete(); ex_full = 0;
            end else begin
                consume = ex_full && ex_allowin;
                move = ds_has && !hazard_stall && (!ex_full || ex_allowin);
                if (consume) void'(q.pop_front());
                ex_full = move || (ex_full && !consume);
                if (fs_valid && exp_allowin) q.push_back('{fs_inst, fs_pc});
            end
            @(posedge clk); #1;
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
